// File: rtl/my_keyboard_ps2.sv
// PS/2 Set-2 keyboard receiver producing Hack key codes.
// Frames are deserialised, validated, then decoded with make/break/E0/shift tracking.
module my_keyboard_ps2 #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_out,
    output logic        key_valid,
    output logic        frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_n;

    logic [1:0]    clk_sync, dat_sync;
    logic          filt, fall, timeout;
    logic [FW-1:0] filt_cnt;
    logic [WW-1:0] wd_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg, byte_q, code, key_code;
    logic          par_bit, good, bad, byte_vld;
    logic          ext_pending, brk_pending, shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            if (clk_sync[1] == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt     <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Falling edge is the cycle the filter accepts a 1->0 change.
    assign fall = filt && !clk_sync[1]
               && (filt_cnt == FW'(FILTER_LEN - 1));

    assign timeout = (state != IDLE) && !fall
                  && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || fall || state == IDLE) wd_cnt <= '0;
        else                                wd_cnt <= wd_cnt + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        good    = 1'b0;
        bad     = 1'b0;
        if (timeout) begin
            state_n = IDLE;
            bad     = 1'b1;
        end else if (fall) begin
            unique case (state)
                IDLE:    if (!dat_sync[1]) state_n = DATA;
                DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
                PARITY:  state_n = STOP;
                STOP: begin
                    state_n = IDLE;
                    if ((^{shreg, par_bit}) && dat_sync[1]) good = 1'b1;
                    else                                   bad  = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            byte_q    <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= good;
            frame_err <= bad;
            if (good) byte_q <= shreg;
            if (fall && state == IDLE) bit_cnt <= '0;
            if (fall && state == DATA) begin
                shreg   <= {dat_sync[1], shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (fall && state == PARITY) par_bit <= dat_sync[1];
        end
    end

    function automatic logic [7:0] map_key(
        input logic       ext,
        input logic [7:0] b,
        input logic       sh
    );
        logic [7:0] c;
        c = 8'd0;
        case ({ext, b})
            9'h01C: c = 8'd65;  9'h032: c = 8'd66;
            9'h021: c = 8'd67;  9'h023: c = 8'd68;
            9'h024: c = 8'd69;  9'h02B: c = 8'd70;
            9'h034: c = 8'd71;  9'h033: c = 8'd72;
            9'h043: c = 8'd73;  9'h03B: c = 8'd74;
            9'h042: c = 8'd75;  9'h04B: c = 8'd76;
            9'h03A: c = 8'd77;  9'h031: c = 8'd78;
            9'h044: c = 8'd79;  9'h04D: c = 8'd80;
            9'h015: c = 8'd81;  9'h02D: c = 8'd82;
            9'h01B: c = 8'd83;  9'h02C: c = 8'd84;
            9'h03C: c = 8'd85;  9'h02A: c = 8'd86;
            9'h01D: c = 8'd87;  9'h022: c = 8'd88;
            9'h035: c = 8'd89;  9'h01A: c = 8'd90;
            9'h045: c = sh ? 8'd41 : 8'd48;
            9'h016: c = sh ? 8'd33 : 8'd49;
            9'h01E: c = sh ? 8'd64 : 8'd50;
            9'h026: c = sh ? 8'd35 : 8'd51;
            9'h025: c = sh ? 8'd36 : 8'd52;
            9'h02E: c = sh ? 8'd37 : 8'd53;
            9'h036: c = sh ? 8'd94 : 8'd54;
            9'h03D: c = sh ? 8'd38 : 8'd55;
            9'h03E: c = sh ? 8'd42 : 8'd56;
            9'h046: c = sh ? 8'd40 : 8'd57;
            9'h029: c = 8'd32;
            9'h04E: c = sh ? 8'd95 : 8'd45;
            9'h055: c = sh ? 8'd43 : 8'd61;
            9'h05A: c = 8'd128; 9'h066: c = 8'd129;
            9'h076: c = 8'd140;
            9'h005: c = 8'd141; 9'h006: c = 8'd142;
            9'h004: c = 8'd143; 9'h00C: c = 8'd144;
            9'h003: c = 8'd145; 9'h00B: c = 8'd146;
            9'h083: c = 8'd147; 9'h00A: c = 8'd148;
            9'h001: c = 8'd149; 9'h009: c = 8'd150;
            9'h078: c = 8'd151; 9'h007: c = 8'd152;
            9'h16B: c = 8'd130; 9'h175: c = 8'd131;
            9'h174: c = 8'd132; 9'h172: c = 8'd133;
            9'h16C: c = 8'd134; 9'h169: c = 8'd135;
            9'h17D: c = 8'd136; 9'h17A: c = 8'd137;
            9'h170: c = 8'd138; 9'h171: c = 8'd139;
            default: c = 8'd0;
        endcase
        return c;
    endfunction

    assign code    = map_key(ext_pending, byte_q, shift);
    assign key_out = {8'h00, key_code};

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            shift       <= 1'b0;
            key_code    <= '0;
            key_valid   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_vld) begin
                if (byte_q == 8'hE0) begin
                    ext_pending <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_pending <= 1'b1;
                end else begin
                    ext_pending <= 1'b0;
                    brk_pending <= 1'b0;
                    if (!ext_pending
                        && (byte_q == 8'h12 || byte_q == 8'h59)) begin
                        shift <= !brk_pending;
                    end else if (code != 8'd0) begin
                        // Break only releases the key currently shown.
                        if (brk_pending) begin
                            if (code == key_code) begin
                                key_code  <= '0;
                                key_valid <= 1'b1;
                            end
                        end else if (code != key_code) begin
                            key_code  <= code;
                            key_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_my_keyboard_ps2.sv
// Bench for my_keyboard_ps2: directed scenarios plus random scancode
// streams compared against a table-driven keyboard model.
module tb_my_keyboard_ps2;
    localparam int HALF = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key_out;
    logic        key_valid;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, kv_tot = 0, fe_tot = 0, kv_cyc = 0;
    int kv_last = 0, fe_last = 0, stop_cyc = 0;

    int lo [256];
    int hi [256];
    int ex [256];
    logic [7:0] mapped [$];
    bit m_ext, m_brk, m_shift;
    int m_key;

    my_keyboard_ps2 dut (
        .clk(clk), .reset(reset),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_out(key_out), .key_valid(key_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (key_valid) begin
            kv_tot <= kv_tot + 1;
            kv_cyc <= cyc;
        end
        if (frame_err) fe_tot <= fe_tot + 1;
    end

    task automatic check(input string tag, input int got,
                         input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic init_tables();
        logic [7:0] let_c [26] = '{
            8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
            8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] dig_c [10] = '{
            8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
            8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        int dig_s [10] = '{41, 33, 64, 35, 36, 37, 94, 38, 42, 40};
        logic [7:0] fk_c [12] = '{
            8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B,
            8'h83, 8'h0A, 8'h01, 8'h09, 8'h78, 8'h07};
        logic [7:0] ex_c [10] = '{
            8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C,
            8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};
        for (int i = 0; i < 256; i++) begin
            lo[i] = 0; hi[i] = 0; ex[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            lo[let_c[i]] = 65 + i; hi[let_c[i]] = 65 + i;
        end
        for (int i = 0; i < 10; i++) begin
            lo[dig_c[i]] = 48 + i; hi[dig_c[i]] = dig_s[i];
        end
        for (int i = 0; i < 12; i++) begin
            lo[fk_c[i]] = 141 + i; hi[fk_c[i]] = 141 + i;
        end
        for (int i = 0; i < 10; i++) ex[ex_c[i]] = 130 + i;
        lo[8'h29] = 32; hi[8'h29] = 32;
        lo[8'h4E] = 45; hi[8'h4E] = 95;
        lo[8'h55] = 61; hi[8'h55] = 43;
        lo[8'h5A] = 128; hi[8'h5A] = 128;
        lo[8'h66] = 129; hi[8'h66] = 129;
        lo[8'h76] = 140; hi[8'h76] = 140;
        for (int i = 0; i < 256; i++)
            if (lo[i] != 0 || ex[i] != 0) mapped.push_back(8'(i));
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shift = 0; m_key = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ekv);
        int c;
        ekv = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext && (b == 8'h12 || b == 8'h59)) begin
                m_shift = !m_brk;
            end else begin
                c = m_ext ? ex[b] : (m_shift ? hi[b] : lo[b]);
                if (c != 0 && m_brk && c == m_key) begin
                    m_key = 0; ekv = 1;
                end else if (c != 0 && !m_brk && c != m_key) begin
                    m_key = c; ekv = 1;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic send_bit(input logic b, input bit is_stop);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit badp);
        logic [10:0] bits;
        logic par;
        par  = (~^b) ^ badp;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], i == 10);
        tick(HALF);
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(i == 0 ? 1'b0 : 1'b1, 0);
        ps2_data = 1'b1;
    endtask

    task automatic post(input string tag, input int ekv, input int efe);
        check({tag, ".key"}, int'(key_out), m_key);
        check({tag, ".kv"}, kv_tot - kv_last, ekv);
        check({tag, ".fe"}, fe_tot - fe_last, efe);
        kv_last = kv_tot;
        fe_last = fe_tot;
    endtask

    task automatic good(input logic [7:0] b, input string tag);
        bit ekv;
        model_byte(b, ekv);
        send_frame(b, 0);
        post(tag, int'(ekv), 0);
    endtask

    initial begin
        int r;
        logic [7:0] b;
        init_tables();
        model_reset();
        tick(5);
        check("rst.key", int'(key_out), 0);
        check("rst.kv", int'(key_valid), 0);
        check("rst.fe", int'(frame_err), 0);
        reset = 1'b0;
        tick(5);

        good(8'h1C, "a_make");
        check("a_code", int'(key_out), 65);
        check("a_lat", int'((kv_cyc - stop_cyc) <= 10), 1);
        good(8'hF0, "a_f0");
        good(8'h1C, "a_brk");
        check("a_zero", int'(key_out), 0);

        good(8'h12, "sh_make");
        good(8'h16, "excl");
        check("excl_code", int'(key_out), 33);
        good(8'hF0, "f0");
        good(8'h16, "excl_brk");
        good(8'hF0, "f0");
        good(8'h12, "sh_brk");
        check("sh_zero", int'(key_out), 0);

        good(8'hE0, "e0");
        good(8'h75, "up");
        check("up_code", int'(key_out), 131);
        good(8'hE0, "e0");
        good(8'hF0, "f0");
        good(8'h75, "up_brk");
        good(8'h1C, "a2");
        good(8'h75, "bare75");
        check("bare75_code", int'(key_out), 65);

        send_frame(8'h1C, 1);
        post("badpar", 0, 1);
        good(8'h32, "b_make");
        check("b_code", int'(key_out), 66);

        send_partial(5);
        tick(5100);
        post("timeout", 0, 1);
        good(8'h29, "space");
        check("space_code", int'(key_out), 32);

        good(8'h1C, "hold1");
        good(8'h1C, "hold2");
        good(8'h1C, "hold3");
        good(8'h32, "b2");
        good(8'hF0, "f0");
        good(8'h1C, "a_brk_other");
        check("stay66", int'(key_out), 66);

        send_partial(5);
        reset = 1'b1;
        tick(3);
        check("mid_rst.key", int'(key_out), 0);
        check("mid_rst.kv", int'(key_valid), 0);
        check("mid_rst.fe", int'(frame_err), 0);
        reset = 1'b0;
        model_reset();
        tick(3);
        kv_last = kv_tot;
        fe_last = fe_tot;
        good(8'h1C, "after_rst");
        check("after_rst_code", int'(key_out), 65);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else if (r == 2) b = $urandom_range(0, 1) ? 8'h12 : 8'h59;
            else if (r == 4) b = 8'($urandom_range(0, 255));
            else b = mapped[$urandom_range(0, mapped.size() - 1)];
            if (r == 3) begin
                send_frame(8'($urandom_range(0, 255)), 1);
                post($sformatf("rnd%0d_bad", i), 0, 1);
            end else begin
                good(b, $sformatf("rnd%0d_%02h", i, b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
